// File: rtl/rtg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtg_pkg
// Description : Shared types and constants for the random test-pattern
//               generator: FSM state encoding, LFSR feedback mask, field
//               widths and the single-step LFSR helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rtg_pkg;

    localparam int C_LFSR_W = 32;
    localparam int C_VEC_W  = 14;
    localparam int C_HOLD_W = 6;
    localparam int C_DET_W  = 11;
    localparam int C_CNT_W  = 16;
    localparam int C_USE_W  = 5;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [C_LFSR_W-1:0] C_LFSR_MASK = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GEN      = 3'd1,
        ST_OFFER    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_EVAL     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // One LFSR advance: shift right, fold the mask in when a 1 falls out.
    function automatic logic [C_LFSR_W-1:0] lfsr_step(input logic [C_LFSR_W-1:0] q);
        return q[0] ? ((q >> 1) ^ C_LFSR_MASK) : (q >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtg_lfsr32.sv
`default_nettype none
// ============================================================================
// Module      : rtg_lfsr32
// Description : 32-bit Galois LFSR with synchronous load and step enable.
//               A zero seed is replaced by 1 so the register never locks up.
// Ports       : clk   - clock
//               reset - asynchronous active-low reset (state -> 32'h1)
//               load  - load seed (priority over step)
//               seed  - load value
//               step  - advance one position
//               q     - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module rtg_lfsr32
    import rtg_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [C_LFSR_W-1:0] seed,
    input  logic                step,
    output logic [C_LFSR_W-1:0] q
);

    logic [C_LFSR_W-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 32'h1;
        end else if (load) begin
            r_q <= (seed == '0) ? 32'h1 : seed;
        end else if (step) begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/rtg_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : rtg_pattern_gen
// Description : Random test-pattern generator campaign controller. Draws
//               vectors from an LFSR, offers them to a fault simulator,
//               keeps vectors that detect at least EF_COUNT new faults and
//               stops on target coverage or UT_LIMIT consecutive useless
//               vectors.
// Ports       : clk, reset (async active-low), start, seed[31:0]
//               vec_valid / vec_ready / vec[13:0] / hold_cycles[5:0]
//               res_valid / res_detected[10:0]
//               busy, done, stop_cov, kept_count[15:0], total_count[15:0],
//               det_total[10:0], useless_count[4:0]
//               With RTG_KEEP_LOG_EN defined: log_valid, log_vec[13:0],
//               log_hold[5:0], log_det[10:0] (one-cycle pulse per kept
//               vector).
// Revision    : 1.0 - initial release
// ============================================================================
module rtg_pattern_gen
    import rtg_pkg::*;
#(
    parameter int NUM_FAULTS = 1317,
    parameter int EF_COUNT   = 3,
    parameter int UT_LIMIT   = 30,
    parameter int COV_PCT    = 95,
    parameter int MAX_CLK    = 50
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [C_LFSR_W-1:0] seed,
    output logic                vec_valid,
    input  logic                vec_ready,
    output logic [C_VEC_W-1:0]  vec,
    output logic [C_HOLD_W-1:0] hold_cycles,
    input  logic                res_valid,
    input  logic [C_DET_W-1:0]  res_detected,
    output logic                busy,
    output logic                done,
    output logic                stop_cov,
    output logic [C_CNT_W-1:0]  kept_count,
    output logic [C_CNT_W-1:0]  total_count,
    output logic [C_DET_W-1:0]  det_total,
    output logic [C_USE_W-1:0]  useless_count
`ifdef RTG_KEEP_LOG_EN
    ,
    output logic                log_valid,
    output logic [C_VEC_W-1:0]  log_vec,
    output logic [C_HOLD_W-1:0] log_hold,
    output logic [C_DET_W-1:0]  log_det
`endif
);

    localparam logic [31:0]          C_MAX_CLK32 = 32'(MAX_CLK);
    localparam logic [C_DET_W-1:0]   C_EF        = C_DET_W'(EF_COUNT);
    localparam logic [C_DET_W:0]     C_NF_EXT    = (C_DET_W+1)'(NUM_FAULTS);
    localparam logic [31:0]          C_UT32      = 32'(UT_LIMIT);
    localparam logic [63:0]          C_COV_THR   = 64'(COV_PCT) * 64'(NUM_FAULTS);

    state_t r_state;
    state_t w_state_nxt;

    logic [C_LFSR_W-1:0] w_lfsr_q;
    logic [C_LFSR_W-1:0] w_lfsr_next;
    logic                w_load;
    logic                w_step;

    logic [C_VEC_W-1:0]  r_vec;
    logic [C_HOLD_W-1:0] r_hold;
    logic [C_DET_W-1:0]  r_captured;
    logic [C_CNT_W-1:0]  r_kept;
    logic [C_CNT_W-1:0]  r_total;
    logic [C_DET_W-1:0]  r_det;
    logic [C_USE_W-1:0]  r_use;
    logic                r_stop_cov;

    logic [C_HOLD_W-1:0] w_raw;
    logic [C_HOLD_W-1:0] w_hold;
    logic                w_kept;
    logic [C_DET_W:0]    w_det_sum;
    logic [C_DET_W-1:0]  w_det_new;
    logic [C_USE_W-1:0]  w_use_new;
    logic                w_cov_hit;
    logic                w_ut_hit;
    logic                w_unused_lfsr_bits;

    // ------------------------------------------------------------------
    // LFSR
    // ------------------------------------------------------------------
    rtg_lfsr32 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .seed  (seed),
        .step  (w_step),
        .q     (w_lfsr_q)
    );

    // The vector is taken from the value the LFSR steps to in GEN, so the
    // first vector of a campaign is one step past the seed.
    assign w_lfsr_next = lfsr_step(w_lfsr_q);
    assign w_raw       = w_lfsr_next[21:16];
    // Fold raw values at or above MAX_CLK back into range.
    assign w_hold      = ({26'd0, w_raw} < C_MAX_CLK32) ? w_raw
                                                        : (w_raw - C_MAX_CLK32[C_HOLD_W-1:0]);
    // Bits not mapped to the vector or hold field.
    assign w_unused_lfsr_bits = ^{w_lfsr_next[31:22], w_lfsr_next[15:14]};

    assign w_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_step = (r_state == ST_GEN);

    // ------------------------------------------------------------------
    // Evaluation of the captured result
    // ------------------------------------------------------------------
    assign w_kept    = (r_captured >= C_EF);
    assign w_det_sum = {1'b0, r_det} + {1'b0, r_captured};
    assign w_det_new = !w_kept             ? r_det :
                       (w_det_sum > C_NF_EXT) ? C_NF_EXT[C_DET_W-1:0] :
                                                w_det_sum[C_DET_W-1:0];
    assign w_use_new = w_kept         ? '0 :
                       (r_use == '1)  ? r_use :
                                        (r_use + 1'b1);
    // 64-bit products so neither side can truncate for any parameter set.
    assign w_cov_hit = (64'(w_det_new) * 64'd100) >= C_COV_THR;
    assign w_ut_hit  = (32'(w_use_new) == C_UT32);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (start)     w_state_nxt = ST_GEN;
            ST_GEN:                     w_state_nxt = ST_OFFER;
            ST_OFFER:    if (vec_ready) w_state_nxt = ST_WAIT_RES;
            ST_WAIT_RES: if (res_valid) w_state_nxt = ST_EVAL;
            ST_EVAL: begin
                if (w_cov_hit || w_ut_hit) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_GEN;
                end
            end
            ST_DONE:     if (start)     w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vec      <= '0;
            r_hold     <= '0;
            r_captured <= '0;
            r_kept     <= '0;
            r_total    <= '0;
            r_det      <= '0;
            r_use      <= '0;
            r_stop_cov <= 1'b0;
        end else if (w_load) begin
            r_kept     <= '0;
            r_total    <= '0;
            r_det      <= '0;
            r_use      <= '0;
            r_stop_cov <= 1'b0;
        end else begin
            case (r_state)
                ST_GEN: begin
                    r_vec  <= w_lfsr_next[C_VEC_W-1:0];
                    r_hold <= w_hold;
                    if (r_total != '1) begin
                        r_total <= r_total + 1'b1;
                    end
                end
                ST_WAIT_RES: begin
                    if (res_valid) begin
                        r_captured <= res_detected;
                    end
                end
                ST_EVAL: begin
                    r_det <= w_det_new;
                    r_use <= w_use_new;
                    if (w_kept && (r_kept != '1)) begin
                        r_kept <= r_kept + 1'b1;
                    end
                    if (w_cov_hit) begin
                        r_stop_cov <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vec_valid     = (r_state == ST_OFFER);
    assign busy          = (r_state == ST_GEN) || (r_state == ST_OFFER) ||
                           (r_state == ST_WAIT_RES) || (r_state == ST_EVAL);
    assign done          = (r_state == ST_DONE);
    assign vec           = r_vec;
    assign hold_cycles   = r_hold;
    assign stop_cov      = r_stop_cov;
    assign kept_count    = r_kept;
    assign total_count   = r_total;
    assign det_total     = r_det;
    assign useless_count = r_use;

`ifdef RTG_KEEP_LOG_EN
    // Presented during EVAL only; r_vec/r_hold still hold the evaluated vector.
    assign log_valid = (r_state == ST_EVAL) && w_kept;
    assign log_vec   = r_vec;
    assign log_hold  = r_hold;
    assign log_det   = r_captured;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtg_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtg_pattern_gen
// Description : Scoreboard bench for rtg_pattern_gen. A campaign model
//               predicts the vector stream and the counters; a monitor pops
//               expected vectors on every accepted handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtg_pattern_gen;

    localparam int NF = 1317;
    localparam int EF = 3;
    localparam int UT = 30;
    localparam int CP = 95;
    localparam int MC = 50;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] seed;
    logic        vec_valid;
    logic        vec_ready;
    logic [13:0] vec;
    logic [5:0]  hold_cycles;
    logic        res_valid;
    logic [10:0] res_detected;
    logic        busy;
    logic        done;
    logic        stop_cov;
    logic [15:0] kept_count;
    logic [15:0] total_count;
    logic [10:0] det_total;
    logic [4:0]  useless_count;

    rtg_pattern_gen #(
        .NUM_FAULTS (NF),
        .EF_COUNT   (EF),
        .UT_LIMIT   (UT),
        .COV_PCT    (CP),
        .MAX_CLK    (MC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .seed          (seed),
        .vec_valid     (vec_valid),
        .vec_ready     (vec_ready),
        .vec           (vec),
        .hold_cycles   (hold_cycles),
        .res_valid     (res_valid),
        .res_detected  (res_detected),
        .busy          (busy),
        .done          (done),
        .stop_cov      (stop_cov),
        .kept_count    (kept_count),
        .total_count   (total_count),
        .det_total     (det_total),
        .useless_count (useless_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [13:0] v;
        logic [5:0]  h;
    } exp_t;

    exp_t exp_q[$];
    int   g_dets[$];
    int   m_use[$];
    int   m_kept[$];
    int   m_det[$];
    int   m_n;
    int   f_kept, f_total, f_det, f_use, f_stop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted offer must match the next predicted vector.
    always @(negedge clk) begin
        if (reset && vec_valid && vec_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_vec: got vec %0d with no prediction", vec);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_vec", 64'(vec), 64'(e.v));
                check("sb_hold", 64'(hold_cycles), 64'(e.h));
            end
            check("hold_below_max", 64'(hold_cycles < 6'(MC)), 64'd1);
        end
    end

    // Polynomial x^32+x^22+x^2+x+1 applied as one right-shift Galois step.
    function automatic logic [31:0] m_step(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h8020_0003;
        return y;
    endfunction

    // Campaign model. gen_random=1 draws fresh detection counts into g_dets;
    // otherwise g_dets is used as supplied.
    task automatic build_model(input logic [31:0] s, input bit gen_random);
        logic [31:0] l;
        int raw, hold, kept, total, det, use_c, d, i;
        exp_t e;
        if (gen_random) g_dets.delete();
        m_use.delete(); m_kept.delete(); m_det.delete();
        l = (s == 0) ? 32'h1 : s;
        kept = 0; total = 0; det = 0; use_c = 0; f_stop = 0;
        i = 0;
        forever begin
            if (gen_random && i >= g_dets.size()) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 5)      g_dets.push_back(int'($urandom_range(0, 2)));
                else if (r < 8) g_dets.push_back(int'($urandom_range(3, 40)));
                else            g_dets.push_back(int'($urandom_range(41, 400)));
            end
            m_use.push_back(use_c);
            m_kept.push_back(kept);
            m_det.push_back(det);
            l = m_step(l);
            raw = int'((l >> 16) & 32'h3f);
            hold = (raw < MC) ? raw : raw - MC;
            e.v = l[13:0];
            e.h = 6'(hold);
            exp_q.push_back(e);
            if (total < 65535) total++;
            d = g_dets[i];
            if (d >= EF) begin
                det = (det + d > NF) ? NF : det + d;
                kept++;
                use_c = 0;
            end else begin
                use_c++;
            end
            i++;
            if (det * 100 >= CP * NF) begin
                f_stop = 1;
                break;
            end
            if (use_c == UT) break;
        end
        m_n = i;
        f_kept = kept; f_total = total; f_det = det; f_use = use_c;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec_valid"}, 64'(vec_valid), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_stop_cov"}, 64'(stop_cov), 0);
        check({tag, "_kept"}, 64'(kept_count), 0);
        check({tag, "_total"}, 64'(total_count), 0);
        check({tag, "_det"}, 64'(det_total), 0);
        check({tag, "_useless"}, 64'(useless_count), 0);
        check({tag, "_vec"}, 64'(vec), 0);
        check({tag, "_hold"}, 64'(hold_cycles), 0);
    endtask

    // Drive one modelled campaign. stall_first: cycles vec_ready stays low
    // on the first offer; inject: pulse res_valid during that stall;
    // abort_at: vector index after whose handshake reset is asserted (-1: none).
    task automatic drive(input logic [31:0] s, input int stall_first,
                         input bit inject, input int abort_at);
        bit ok;
        seed = s;
        if (done) begin
            pulse_start();
            check("done_to_idle_done", 64'(done), 0);
            check("done_to_idle_busy", 64'(busy), 0);
            check("done_to_idle_stop", 64'(stop_cov), 0);
            check("done_to_idle_total", 64'(total_count), 0);
        end
        pulse_start();
        for (int i = 0; i < m_n; i++) begin
            int stall;
            ok = 0;
            for (int w = 0; w < 20; w++) begin
                if (vec_valid) begin ok = 1; break; end
                tick();
            end
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL offer_timeout: vec_valid 0 after 20 cycles, expected 1");
                exp_q.delete();
                return;
            end
            check("total_at_offer", 64'(total_count), 64'(i + 1));
            check("useless_at_offer", 64'(useless_count), 64'(m_use[i]));
            check("kept_at_offer", 64'(kept_count), 64'(m_kept[i]));
            check("det_at_offer", 64'(det_total), 64'(m_det[i]));
            check("busy_at_offer", 64'(busy), 1);
            if (i == 0 && s == 32'h1) begin
                check("first_vec_seed1", 64'(vec), 64'h3);
                check("first_hold_seed1", 64'(hold_cycles), 64'd32);
            end
            stall = (i == 0) ? stall_first : int'($urandom_range(0, 3));
            vec_ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                if (inject && i == 0 && k == 2) begin
                    res_valid = 1'b1;
                    res_detected = 11'd1000;
                end else begin
                    res_valid = 1'b0;
                end
                tick();
            end
            res_valid = 1'b0;
            if (i == 0 && stall_first >= 20) begin
                check("stall_valid", 64'(vec_valid), 1);
                check("stall_vec", 64'(vec), 64'(exp_q[0].v));
                check("stall_hold", 64'(hold_cycles), 64'(exp_q[0].h));
                check("stall_total", 64'(total_count), 1);
            end
            vec_ready = 1'b1;
            tick();
            vec_ready = 1'b0;
            check("valid_drops_after_accept", 64'(vec_valid), 0);
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                check_all_zero("reset_wait_res");
                tick();
                tick();
                reset = 1'b1;
                exp_q.delete();
                check_all_zero("after_reset");
                return;
            end
            repeat ($urandom_range(0, 2)) tick();
            res_valid = 1'b1;
            res_detected = 11'(g_dets[i]);
            tick();
            res_valid = 1'b0;
            res_detected = 11'($urandom_range(0, 2047));
        end
        ok = 0;
        for (int w = 0; w < 10; w++) begin
            if (done) begin ok = 1; break; end
            tick();
        end
        check("campaign_done", 64'(ok), 1);
        check("final_busy", 64'(busy), 0);
        check("final_stop_cov", 64'(stop_cov), 64'(f_stop));
        check("final_kept", 64'(kept_count), 64'(f_kept));
        check("final_total", 64'(total_count), 64'(f_total));
        check("final_det", 64'(det_total), 64'(f_det));
        check("final_useless", 64'(useless_count), 64'(f_use));
        check("sb_drained", 64'(exp_q.size()), 0);
    endtask

    initial begin
        logic [31:0] s;
        reset = 1'b0;
        start = 1'b0;
        seed = '0;
        vec_ready = 1'b0;
        res_valid = 1'b0;
        res_detected = '0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Seed 1: stalled first offer with a stray result pulse, then a
        // keepable result clearing the useless run, then 30 useless.
        g_dets.delete();
        g_dets.push_back(2);
        g_dets.push_back(2);
        g_dets.push_back(5);
        repeat (30) g_dets.push_back(2);
        build_model(32'h1, 1'b0);
        drive(32'h1, 20, 1'b1, -1);

        // Thirty useless vectors in a row (also exercises DONE -> IDLE).
        g_dets.delete();
        repeat (30) g_dets.push_back(2);
        s = $urandom;
        build_model(s, 1'b0);
        drive(s, 0, 1'b0, -1);
        check("ut_stop_cov", 64'(stop_cov), 0);
        check("ut_total", 64'(total_count), 30);
        check("ut_useless", 64'(useless_count), 30);

        // Coverage reached on the second vector: 700 + 552 = 1252.
        g_dets.delete();
        g_dets.push_back(700);
        g_dets.push_back(552);
        s = $urandom;
        build_model(s, 1'b0);
        drive(s, 0, 1'b0, -1);
        check("cov_det", 64'(det_total), 1252);
        check("cov_stop", 64'(stop_cov), 1);
        check("cov_kept", 64'(kept_count), 2);

        // Randomized campaigns, including a zero seed.
        for (int c = 0; c < 4; c++) begin
            s = (c == 0) ? 32'h0 : $urandom;
            build_model(s, 1'b1);
            drive(s, int'($urandom_range(0, 4)), 1'b0, -1);
        end

        // Reset while waiting for a result, then replay the same seed.
        s = $urandom;
        build_model(s, 1'b1);
        drive(s, 0, 1'b0, 2);
        build_model(s, 1'b0);
        drive(s, 0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not end, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/rtg_pattern_gen.md
RTG_PATTERN_GEN -- requirements
Module: rtg_pattern_gen

Interface
REQ-001 SHALL have parameters: NUM_FAULTS, default 1317, size of the fault list; EF_COUNT, default 3, minimum detections for a vector to be kept; UT_LIMIT, default 30, consecutive useless vectors before stopping; COV_PCT, default 95, target coverage in percent; MAX_CLK, default 50, exclusive bound on hold cycles.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle pulse in IDLE begins a campaign.
REQ-005 SHALL have port seed, input, 32 bits: LFSR seed, sampled on start; a zero value is replaced by 32'h1.
REQ-006 SHALL have ports vec_valid (output, 1 bit), vec_ready (input, 1 bit), vec (output, 14 bits) and hold_cycles (output, 6 bits): offer to the fault-simulation stage.
REQ-007 SHALL have ports res_valid (input, 1 bit) and res_detected (input, 11 bits): new detections reported for the last accepted vector.
REQ-008 SHALL have outputs busy (1), done (1), stop_cov (1), kept_count (16), total_count (16), det_total (11) and useless_count (5).

Function
REQ-009 SHALL implement the FSM IDLE -> GEN -> OFFER -> WAIT_RES -> EVAL -> (GEN | DONE); DONE -> IDLE only on start.
REQ-010 SHALL use a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003) and advance it exactly once per GEN cycle.
REQ-011 SHALL, in GEN: vec = lfsr[13:0]; raw = lfsr[21:16]; hold_cycles = raw if raw < MAX_CLK, else raw - MAX_CLK; total_count increments.
REQ-012 SHALL hold vec_valid high in OFFER with vec and hold_cycles stable until the cycle in which vec_valid && vec_ready, then go to WAIT_RES.
REQ-013 SHALL ignore res_valid in every state except WAIT_RES; in WAIT_RES, res_valid captures res_detected and moves to EVAL.
REQ-014 SHALL, in EVAL with captured value >= EF_COUNT: det_total += value, saturating at NUM_FAULTS; kept_count increments; useless_count clears.
REQ-015 SHALL, in EVAL with captured value < EF_COUNT: useless_count increments.
REQ-016 SHALL, in EVAL, go to DONE with stop_cov=1 if det_total*100 >= COV_PCT*NUM_FAULTS, evaluated with the updated det_total and full-width unsigned arithmetic with no truncation.
REQ-017 SHALL, in EVAL, otherwise go to DONE with stop_cov=0 if useless_count == UT_LIMIT; coverage takes priority when both conditions hold; otherwise go to GEN.
REQ-018 SHALL drive busy=1 in GEN, OFFER, WAIT_RES and EVAL, and done=1 only in DONE.
REQ-019 SHALL, on start in IDLE or DONE, clear all counters and stop_cov and load the LFSR; start in any other state SHALL be ignored.
REQ-020 SHALL saturate kept_count and total_count at all-ones.

Reset
REQ-021 SHALL, on reset low, immediately force: state IDLE; lfsr 32'h1; vec, hold_cycles, all counters, det_total, vec_valid, busy, done and stop_cov all 0.
REQ-022 SHALL make reset mid-campaign abandon any outstanding offer or result with no further outputs until the next start.

Configuration
REQ-023 SHALL, with RTG_KEEP_LOG_EN defined, add outputs log_valid (1), log_vec (14), log_hold (6) and log_det (11), pulsing log_valid for one cycle on each kept vector in EVAL.
REQ-024 SHALL, without RTG_KEEP_LOG_EN, omit those ports, their logic and their registers entirely.

Structure
REQ-025 SHALL place the FSM state enum, the LFSR mask constant and the count widths in package rtg_pkg.
REQ-026 SHALL implement the LFSR as sub-module rtg_lfsr32 (ports: clk, reset, load, seed, step, q).

Verification
REQ-027 SHALL verify: seed 32'h1 and start, vec_ready=1 -> first vec equals lfsr[13:0] after one step from 1, and hold_cycles < 50 on every vector.
REQ-028 SHALL verify: vec_ready held low 20 cycles in OFFER -> vec_valid stays 1, vec and hold_cycles unchanged, total_count unchanged.
REQ-029 SHALL verify: res_detected = 2 thirty times -> done=1, stop_cov=0, kept_count=0, useless_count=30, total_count=30.
REQ-030 SHALL verify: res_detected = 700 then 552 -> det_total=1252 (>= 1251.15), done=1, stop_cov=1, kept_count=2.
REQ-031 SHALL verify: res_valid pulsed in OFFER -> ignored; res_detected=5 after handshake -> useless_count clears to 0.
REQ-032 SHALL verify: reset asserted in WAIT_RES -> all outputs 0 within the same cycle; restart with the same seed reproduces the same vector sequence.
